// File: rtl/time_base_pkg.sv
// Shared constants for the multi-channel timebase: default widths and divisors
// derived from the 16.368 MHz reference clock.
package time_base_pkg;

  localparam int unsigned REF_CLK_HZ = 16_368_000;

  // Pulse periods in reference-clock cycles: 0.1 s TIC, 0.9 ms accumulation.
  localparam int unsigned TIC_PERIOD_CYC = REF_CLK_HZ / 10;
  localparam int unsigned ACC_PERIOD_CYC = 14_731;

  localparam int unsigned DEF_CNT_W = 24;

  // A divisor of d yields a period of d+1 cycles.
  function automatic logic [DEF_CNT_W-1:0] div_for_period(input int unsigned cycles);
    return DEF_CNT_W'(cycles - 1);
  endfunction

  localparam logic [DEF_CNT_W-1:0] DEF_TIC_DIV = div_for_period(TIC_PERIOD_CYC);  // 24'h18F9BF
  localparam logic [DEF_CNT_W-1:0] DEF_ACC_DIV = div_for_period(ACC_PERIOD_CYC);  // 24'h398A

endpackage

// File: rtl/tb_div_chan.sv
// One divider channel: down-counter with shadow-buffered divisor, run gating and
// an optional phase-realign (sync) input.
module tb_div_chan
  import time_base_pkg::*;
#(
  parameter int unsigned      CNT_W    = DEF_CNT_W,
  parameter logic [CNT_W-1:0] DEF      = CNT_W'(DEF_ACC_DIV),
  parameter bit               HAS_SYNC = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [CNT_W-1:0] divide,
  input  logic             div_wr,
  input  logic             sync_in,
  output logic             pulse,
  output logic [CNT_W-1:0] count,
  output logic             slip
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] active_q;
  logic [CNT_W-1:0] pending_q;
  logic             pend_q;
  logic             slip_q;
  logic [CNT_W-1:0] eff_div;
  logic             reload;
  logic             do_sync;

  // A write landing on the reload cycle takes effect for that very reload.
  always_comb begin
    eff_div = active_q;
    if (div_wr) begin
      eff_div = divide;
    end else if (pend_q) begin
      eff_div = pending_q;
    end
  end

  assign pulse   = run && (cnt_q == '0);
  assign reload  = !run || pulse;
  assign do_sync = HAS_SYNC && run && sync_in && (cnt_q != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= DEF;
      active_q  <= DEF;
      pending_q <= DEF;
      pend_q    <= 1'b0;
      slip_q    <= 1'b0;
    end else begin
      slip_q <= 1'b0;
      if (reload) begin
        cnt_q    <= eff_div;
        active_q <= eff_div;
        pend_q   <= 1'b0;
      end else begin
        if (div_wr) begin
          pending_q <= divide;
          pend_q    <= 1'b1;
        end
        if (do_sync) begin
          cnt_q  <= '0;
          slip_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q - 1'b1;
        end
      end
    end
  end

  assign count = cnt_q;
  assign slip  = slip_q;

endmodule

// File: rtl/time_base_multi.sv
// Multi-channel timebase: preTIC/TIC pair with configurable lag, elapsed-TIC
// counter, and N_ACC independent accumulation-interrupt dividers.
module time_base_multi
  import time_base_pkg::*;
#(
  parameter int unsigned      CNT_W     = DEF_CNT_W,
  parameter int unsigned      N_ACC     = 2,
  parameter int unsigned      TIC_LAG   = 1,
  parameter int unsigned      TIC_NUM_W = 32,
  parameter logic [CNT_W-1:0] TIC_DEF   = CNT_W'(DEF_TIC_DIV),
  parameter logic [CNT_W-1:0] ACC_DEF   = CNT_W'(DEF_ACC_DIV)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run,
  input  logic [CNT_W-1:0]       tic_divide,
  input  logic                   tic_div_wr,
  input  logic [N_ACC*CNT_W-1:0] accum_divide,
  input  logic [N_ACC-1:0]       accum_div_wr,
  input  logic                   sync_in,
  output logic                   pre_tic_enable,
  output logic                   tic_enable,
  output logic [N_ACC-1:0]       accum_enable,
  output logic [CNT_W-1:0]       tic_count,
  output logic [N_ACC*CNT_W-1:0] accum_count,
  output logic [TIC_NUM_W-1:0]   tic_num,
  output logic                   sync_slip
);

  logic [TIC_LAG-1:0]   lag_q;
  logic [TIC_LAG-1:0]   lag_d;
  logic [TIC_NUM_W-1:0] tic_num_q;
  logic                 run_q;

  tb_div_chan #(
    .CNT_W    (CNT_W),
    .DEF      (TIC_DEF),
    .HAS_SYNC (1'b1)
  ) u_tic_chan (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
    .divide  (tic_divide),
    .div_wr  (tic_div_wr),
    .sync_in (sync_in),
    .pulse   (pre_tic_enable),
    .count   (tic_count),
    .slip    (sync_slip)
  );

  for (genvar k = 0; k < int'(N_ACC); k++) begin : g_acc
    logic acc_slip_unused;

    tb_div_chan #(
      .CNT_W    (CNT_W),
      .DEF      (ACC_DEF),
      .HAS_SYNC (1'b0)
    ) u_acc_chan (
      .clk     (clk),
      .rst     (rst),
      .run     (run),
      .divide  (accum_divide[k*CNT_W +: CNT_W]),
      .div_wr  (accum_div_wr[k]),
      .sync_in (1'b0),
      .pulse   (accum_enable[k]),
      .count   (accum_count[k*CNT_W +: CNT_W]),
      .slip    (acc_slip_unused)
    );
  end

  // The lag line keeps shifting regardless of run so in-flight pulses still emerge.
  always_comb begin
    lag_d    = lag_q << 1;
    lag_d[0] = pre_tic_enable;
  end

  assign tic_enable = lag_q[TIC_LAG-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lag_q     <= '0;
      tic_num_q <= '0;
      run_q     <= 1'b0;
    end else begin
      lag_q <= lag_d;
      run_q <= run;
      if (run && !run_q) begin
        tic_num_q <= '0;
      end else if (run && tic_enable) begin
        tic_num_q <= tic_num_q + 1'b1;
      end
    end
  end

  assign tic_num = tic_num_q;

endmodule

// File: tb/tb_time_base_multi.sv
// Randomised scoreboard bench for time_base_multi against an absolute-time model.
module tb_time_base_multi;

  localparam int unsigned      CNT_W     = 24;
  localparam int unsigned      N_ACC     = 2;
  localparam int unsigned      TIC_LAG   = 3;
  localparam int unsigned      TIC_NUM_W = 4;
  localparam logic [CNT_W-1:0] TIC_DEF   = 24'd19;
  localparam logic [CNT_W-1:0] ACC_DEF   = 24'd6;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   run = 1'b0;
  logic [CNT_W-1:0]       tic_divide = '0;
  logic                   tic_div_wr = 1'b0;
  logic [N_ACC*CNT_W-1:0] accum_divide = '0;
  logic [N_ACC-1:0]       accum_div_wr = '0;
  logic                   sync_in = 1'b0;
  logic                   pre_tic_enable;
  logic                   tic_enable;
  logic [N_ACC-1:0]       accum_enable;
  logic [CNT_W-1:0]       tic_count;
  logic [N_ACC*CNT_W-1:0] accum_count;
  logic [TIC_NUM_W-1:0]   tic_num;
  logic                   sync_slip;

  time_base_multi #(
    .CNT_W     (CNT_W),
    .N_ACC     (N_ACC),
    .TIC_LAG   (TIC_LAG),
    .TIC_NUM_W (TIC_NUM_W),
    .TIC_DEF   (TIC_DEF),
    .ACC_DEF   (ACC_DEF)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .run            (run),
    .tic_divide     (tic_divide),
    .tic_div_wr     (tic_div_wr),
    .accum_divide   (accum_divide),
    .accum_div_wr   (accum_div_wr),
    .sync_in        (sync_in),
    .pre_tic_enable (pre_tic_enable),
    .tic_enable     (tic_enable),
    .accum_enable   (accum_enable),
    .tic_count      (tic_count),
    .accum_count    (accum_count),
    .tic_num        (tic_num),
    .sync_slip      (sync_slip)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                     cyc;
    logic                   pre;
    logic                   tic;
    logic [N_ACC-1:0]       acc_en;
    logic [CNT_W-1:0]       tic_cnt;
    logic [N_ACC*CNT_W-1:0] acc_cnt;
    logic [TIC_NUM_W-1:0]   num;
    logic                   slip;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Model: each channel (0 = TIC, 1.. = accum) tracks the absolute cycle of its next pulse.
  int          now;
  int          due     [N_ACC+1];
  int unsigned act     [N_ACC+1];
  int unsigned pend_v  [N_ACC+1];
  bit          pend    [N_ACC+1];
  int          tic_at[$];
  int unsigned num;
  int          slip_at;
  bit          run_prev;

  function automatic int unsigned def_of(input int c);
    return (c == 0) ? int'(TIC_DEF) : int'(ACC_DEF);
  endfunction

  task automatic model_reset(input int base);
    for (int c = 0; c <= N_ACC; c++) begin
      due[c]  = base + int'(def_of(c));
      act[c]  = def_of(c);
      pend[c] = 1'b0;
    end
    tic_at.delete();
    num      = 0;
    slip_at  = -1;
    run_prev = 1'b0;
  endtask

  task automatic step(input bit r, input bit rn, input bit tw, input int unsigned td,
                      input logic [N_ACC-1:0] aw, input int unsigned ad0,
                      input int unsigned ad1, input bit sy);
    exp_t        e;
    int          disp  [N_ACC+1];
    bit          pls   [N_ACC+1];
    bit          wr;
    int unsigned dv;
    int unsigned eff;
    bit          fire;
    @(negedge clk);
    rst          = r;
    run          = rn;
    tic_div_wr   = tw;
    tic_divide   = CNT_W'(td);
    accum_div_wr = aw;
    accum_divide = {CNT_W'(ad1), CNT_W'(ad0)};
    sync_in      = sy;
    if (r) model_reset(now);
    for (int c = 0; c <= N_ACC; c++) begin
      disp[c] = due[c] - now;
      pls[c]  = !r && rn && (disp[c] == 0);
    end
    fire      = !r && (tic_at.size() > 0) && (tic_at[0] == now);
    e.cyc     = now;
    e.pre     = pls[0];
    e.tic     = fire;
    e.acc_en  = {pls[2], pls[1]};
    e.tic_cnt = CNT_W'(disp[0]);
    e.acc_cnt = {CNT_W'(disp[2]), CNT_W'(disp[1])};
    e.num     = TIC_NUM_W'(num);
    e.slip    = !r && (slip_at == now);
    exp_q.push_back(e);
    if (r) begin
      model_reset(now + 1);
    end else begin
      if (fire) void'(tic_at.pop_front());
      if (rn && !run_prev) num = 0;
      else if (rn && fire) num = (num + 1) % (1 << TIC_NUM_W);
      run_prev = rn;
      if (pls[0]) tic_at.push_back(now + TIC_LAG);
      for (int c = 0; c <= N_ACC; c++) begin
        wr  = (c == 0) ? tw : aw[c-1];
        dv  = (c == 0) ? td : ((c == 1) ? ad0 : ad1);
        eff = wr ? dv : (pend[c] ? pend_v[c] : act[c]);
        if (!rn || pls[c]) begin
          act[c]  = eff;
          pend[c] = 1'b0;
          due[c]  = now + 1 + int'(eff);
        end else begin
          if (wr) begin
            pend_v[c] = dv;
            pend[c]   = 1'b1;
          end
          if (c == 0 && sy && disp[c] != 0) begin
            due[c]  = now + 1;
            slip_at = now + 1;
          end
        end
      end
    end
    now++;
  endtask

  task automatic idle_step(input bit rn);
    step(1'b0, rn, 1'b0, 0, '0, 0, 0, 1'b0);
  endtask

  task automatic chk(input string name, input int cyc, input logic [63:0] got,
                     input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, want);
    end
  endtask

  // Monitor: the DUT presents a fresh output set every cycle; compare mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pre_tic_enable", e.cyc, 64'(pre_tic_enable), 64'(e.pre));
        chk("tic_enable", e.cyc, 64'(tic_enable), 64'(e.tic));
        chk("accum_enable", e.cyc, 64'(accum_enable), 64'(e.acc_en));
        chk("tic_count", e.cyc, 64'(tic_count), 64'(e.tic_cnt));
        chk("accum_count", e.cyc, 64'(accum_count), 64'(e.acc_cnt));
        chk("tic_num", e.cyc, 64'(tic_num), 64'(e.num));
        chk("sync_slip", e.cyc, 64'(sync_slip), 64'(e.slip));
      end
    end
  end

  initial begin
    int n;
    bit r;
    now = 0;
    model_reset(0);

    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 0, '0, 0, 0, 1'b0);
    // Idle divisor writes, then run: TIC every 4, ch0 every 3, ch1 every cycle.
    step(1'b0, 1'b0, 1'b1, 3, 2'b11, 2, 0, 1'b0);
    idle_step(1'b0);
    for (int i = 0; i < 20; i++) idle_step(1'b1);
    step(1'b0, 1'b1, 1'b0, 0, 2'b10, 0, 1, 1'b0);
    for (int i = 0; i < 10; i++) idle_step(1'b1);

    // Divisor 9, then a mid-period write of 4 at count 5.
    step(1'b0, 1'b0, 1'b1, 9, '0, 0, 0, 1'b0);
    idle_step(1'b0);
    n = 0;
    while (due[0] - now != 5 && n < 50) begin idle_step(1'b1); n++; end
    step(1'b0, 1'b1, 1'b1, 4, '0, 0, 0, 1'b0);
    for (int i = 0; i < 20; i++) idle_step(1'b1);

    // Sync off-phase at count 6, then sync coincident with count 0.
    step(1'b0, 1'b0, 1'b1, 9, '0, 0, 0, 1'b0);
    idle_step(1'b0);
    n = 0;
    while (due[0] - now != 6 && n < 50) begin idle_step(1'b1); n++; end
    step(1'b0, 1'b1, 1'b0, 0, '0, 0, 0, 1'b1);
    n = 0;
    while (due[0] - now != 0 && n < 50) begin idle_step(1'b1); n++; end
    step(1'b0, 1'b1, 1'b0, 0, '0, 0, 0, 1'b1);
    for (int i = 0; i < 15; i++) idle_step(1'b1);

    // Drop run the cycle after a preTIC: the lagged TIC must still emerge.
    n = 0;
    while (due[0] - now != 0 && n < 50) begin idle_step(1'b1); n++; end
    idle_step(1'b1);
    for (int i = 0; i < 6; i++) idle_step(1'b0);

    // Randomised traffic with occasional async resets.
    for (int i = 0; i < 4000; i++) begin
      r = ($urandom_range(0, 399) == 0);
      step(r, ($urandom_range(0, 19) != 0), ($urandom_range(0, 15) == 0),
           $urandom_range(0, 12),
           {($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0)},
           $urandom_range(0, 8), $urandom_range(0, 8), ($urandom_range(0, 11) == 0));
    end

    // Reset mid-count, release with run=1: first preTIC after TIC_DEF+1 cycles.
    for (int i = 0; i < 7; i++) idle_step(1'b1);
    step(1'b1, 1'b1, 1'b0, 0, '0, 0, 0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 0, '0, 0, 0, 1'b0);
    for (int i = 0; i < 30; i++) idle_step(1'b1);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", now, 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
